// File: rtl/tl_timer_pkg.sv
// Shared definitions for the interval timer and the light-sequencing controller:
// interval codes, parameter-select codes, default durations, counter widths.
package tl_timer_pkg;

  localparam int unsigned CNT_W   = 5;
  localparam int unsigned PARAM_W = 4;

  localparam int unsigned TBASE_DEF_S = 6;
  localparam int unsigned TEXT_DEF_S  = 3;
  localparam int unsigned TYEL_DEF_S  = 2;

  typedef enum logic [1:0] {
    TB   = 2'b00,
    TE   = 2'b01,
    TY   = 2'b10,
    TBX2 = 2'b11
  } interval_e;

  typedef enum logic [1:0] {
    SEL_BASE = 2'b00,
    SEL_EXT  = 2'b01,
    SEL_YEL  = 2'b10,
    SEL_RSVD = 2'b11
  } param_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

  // A programmed value of zero means "restore the default".
  function automatic logic [PARAM_W-1:0] resolve_param(input logic [PARAM_W-1:0] value,
                                                       input logic [PARAM_W-1:0] dflt);
    return (value == '0) ? dflt : value;
  endfunction

  // Duration in seconds for an interval code; 2*tBASE fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] lookup_duration(input logic [1:0]         code,
                                                       input logic [PARAM_W-1:0] tb,
                                                       input logic [PARAM_W-1:0] te,
                                                       input logic [PARAM_W-1:0] ty);
    logic [CNT_W-1:0] dur;
    case (code)
      TB:      dur = {1'b0, tb};
      TE:      dur = {1'b0, te};
      TY:      dur = {1'b0, ty};
      default: dur = {tb, 1'b0};
    endcase
    return dur;
  endfunction

endpackage

// File: rtl/interval_timer_tick_prescaler.sv
// Free-running divide-by-DIV counter producing a one-cycle tick each DIV cycles.
// A synchronous clear realigns the phase so a fresh interval starts a full period.
module tick_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  assign o_tick = (r_count == LAST);

  // Divisor counter: wraps on tick, returns to zero on clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Interval timer: times the selected duration in 1 s ticks after start_timer
// and returns a one-cycle expired pulse. Holds programmable tBASE/tEXT/tYEL.
// Build option: TIMER_FAST_SIM_EN forces the tick divisor to 4 for simulation.
module interval_timer
  import tl_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned TBASE_DEF = TBASE_DEF_S,
  parameter int unsigned TEXT_DEF  = TEXT_DEF_S,
  parameter int unsigned TYEL_DEF  = TYEL_DEF_S
) (
  input  logic                clk,
  input  logic                Reset_N,
  input  logic                start_timer,
  input  logic [1:0]          interval,
  input  logic                Prog_Sync,
  input  logic [1:0]          Time_Param_Sel,
  input  logic [PARAM_W-1:0]  Time_Value,
  output logic                expired
);

`ifdef TIMER_FAST_SIM_EN
  localparam int unsigned DIV_EFF = 4;
`else
  localparam int unsigned DIV_EFF = TICK_DIV;
`endif

  localparam logic [PARAM_W-1:0] TBASE_D = PARAM_W'(TBASE_DEF);
  localparam logic [PARAM_W-1:0] TEXT_D  = PARAM_W'(TEXT_DEF);
  localparam logic [PARAM_W-1:0] TYEL_D  = PARAM_W'(TYEL_DEF);

  timer_state_e       r_state;
  timer_state_e       w_state_nxt;
  logic [CNT_W-1:0]   r_remaining;
  logic [CNT_W-1:0]   w_remaining_nxt;
  logic               r_expired;
  logic               w_expired_nxt;
  logic [PARAM_W-1:0] r_tbase, r_text, r_tyel;
  logic [PARAM_W-1:0] w_tbase, w_text, w_tyel;
  logic [CNT_W-1:0]   w_duration;
  logic               w_tick;

  tick_prescaler #(
    .DIV (DIV_EFF)
  ) u_prescaler (
    .i_clk   (clk),
    .i_rst_n (Reset_N),
    .i_clear (start_timer),
    .o_tick  (w_tick)
  );

  // Parameter values as seen this cycle, with a same-cycle write forwarded.
  always_comb begin
    w_tbase = r_tbase;
    w_text  = r_text;
    w_tyel  = r_tyel;
    if (Prog_Sync) begin
      case (Time_Param_Sel)
        SEL_BASE: w_tbase = resolve_param(Time_Value, TBASE_D);
        SEL_EXT:  w_text  = resolve_param(Time_Value, TEXT_D);
        SEL_YEL:  w_tyel  = resolve_param(Time_Value, TYEL_D);
        default:  ;
      endcase
    end
  end

  assign w_duration = lookup_duration(interval, w_tbase, w_text, w_tyel);

  // Parameter registers: the forwarded view already contains any write.
  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_tbase <= TBASE_D;
      r_text  <= TEXT_D;
      r_tyel  <= TYEL_D;
    end else begin
      r_tbase <= w_tbase;
      r_text  <= w_text;
      r_tyel  <= w_tyel;
    end
  end

  // Next state: a start always reloads and suppresses a coincident expiry.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_expired_nxt   = 1'b0;
    if (start_timer) begin
      w_state_nxt     = ST_RUN;
      w_remaining_nxt = w_duration;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_tick) begin
            if (r_remaining == CNT_W'(1)) begin
              w_state_nxt     = ST_IDLE;
              w_remaining_nxt = '0;
              w_expired_nxt   = 1'b1;
            end else begin
              w_remaining_nxt = r_remaining - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, countdown and registered expiry pulse.
  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_expired   <= w_expired_nxt;
    end
  end

  assign expired = r_expired;

endmodule
